// File: rtl/uart_rx_frame_parser.sv
// UART RX frame parser: drains the RX FIFO one byte at a time and turns
// AA 55 LEN PAYLOAD[LEN] CHK frames into a payload stream plus frame status.

module uart_rx_frame_parser #(
   parameter int unsigned MAX_LEN     = 32,
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter logic [7:0]  HDR0        = 8'hAA,
   parameter logic [7:0]  HDR1        = 8'h55
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       En,
   input  logic       Empty_sig,
   input  logic [7:0] FIFO_RD_Dat,
   output logic       RD_Req_sig,
   output logic [7:0] Pay_Dat,
   output logic       Pay_Vld,
   output logic [7:0] Pay_Idx,
   output logic [7:0] Frame_Len,
   output logic       Frame_Done,
   output logic [1:0] Frame_Err
);

   typedef enum logic [2:0] {
      S_H0,
      S_H1,
      S_LEN,
      S_PAY,
      S_CHK
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_CHK  = 2'd1,
      ERR_LEN  = 2'd2,
      ERR_TMO  = 2'd3
   } err_t;

   localparam int unsigned   TW        = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   state_t        state_q,   state_d;
   logic          rd_pend_q, rd_pend_d;
   logic [TW-1:0] timer_q,   timer_d;
   logic [7:0]    sum_q,     sum_d;
   logic [7:0]    idx_q,     idx_d;
   logic [7:0]    len_q,     len_d;
   logic [7:0]    pay_dat_q, pay_dat_d;
   logic [7:0]    pay_idx_q, pay_idx_d;
   logic          pay_vld_q, pay_vld_d;
   logic          done_q,    done_d;
   err_t          err_q,     err_d;

   logic          byte_vld;
   logic [7:0]    rx_byte;

   // Only one read may be in flight; the FIFO answers the cycle after the request.
   assign RD_Req_sig = En & ~Empty_sig & ~rd_pend_q & ~RST;
   assign byte_vld   = rd_pend_q;
   assign rx_byte    = FIFO_RD_Dat;
   assign rd_pend_d  = RD_Req_sig;

   always_comb begin
      // NOTE: every _d gets its hold/idle value first so no path can infer a latch.
      state_d   = state_q;
      timer_d   = timer_q;
      sum_d     = sum_q;
      idx_d     = idx_q;
      len_d     = len_q;
      pay_dat_d = pay_dat_q;
      pay_idx_d = pay_idx_q;
      pay_vld_d = 1'b0;
      done_d    = 1'b0;
      err_d     = ERR_NONE;

      if (byte_vld) begin
         timer_d = '0;
         case (state_q)
            S_H0: begin
               if (rx_byte == HDR0) state_d = S_H1;
            end
            S_H1: begin
               if (rx_byte == HDR1)      state_d = S_LEN;
               else if (rx_byte != HDR0) state_d = S_H0;
            end
            S_LEN: begin
               len_d = rx_byte;
               sum_d = rx_byte;
               if (rx_byte > MAX_LEN_B) begin
                  err_d   = ERR_LEN;
                  state_d = S_H0;
               end else if (rx_byte == 8'd0) begin
                  state_d = S_CHK;
               end else begin
                  idx_d   = 8'd0;
                  state_d = S_PAY;
               end
            end
            S_PAY: begin
               pay_dat_d = rx_byte;
               pay_idx_d = idx_q;
               pay_vld_d = 1'b1;
               sum_d     = sum_q + rx_byte;
               if (idx_q == len_q - 8'd1) state_d = S_CHK;
               else                       idx_d   = idx_q + 8'd1;
            end
            S_CHK: begin
               if (rx_byte == sum_q) done_d = 1'b1;
               else                  err_d  = ERR_CHK;
               state_d = S_H0;
            end
            default: state_d = S_H0;
         endcase
      end else if (state_q == S_H0) begin
         timer_d = '0;
      end else if (timer_q == TMO_LAST) begin
         // A byte landing in the expiry cycle takes the branch above instead.
         err_d   = ERR_TMO;
         state_d = S_H0;
         timer_d = '0;
         sum_d   = '0;
         idx_d   = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: data/index/length regs are reset too because every output must read 0 after RST.
         state_q   <= S_H0;
         rd_pend_q <= 1'b0;
         timer_q   <= '0;
         sum_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         pay_dat_q <= '0;
         pay_idx_q <= '0;
         pay_vld_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= ERR_NONE;
      end else begin
         // NOTE: non-blocking only in the clocked block; all next-state logic lives in always_comb.
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         timer_q   <= timer_d;
         sum_q     <= sum_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         pay_dat_q <= pay_dat_d;
         pay_idx_q <= pay_idx_d;
         pay_vld_q <= pay_vld_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign Pay_Dat    = pay_dat_q;
   assign Pay_Vld    = pay_vld_q;
   assign Pay_Idx    = pay_idx_q;
   assign Frame_Len  = len_q;
   assign Frame_Done = done_q;
   assign Frame_Err  = err_q;

   // Done and error come from exclusive branches of the same consume path.
   assert property (@(posedge CLK) disable iff (RST) !(Frame_Done && (Frame_Err != 2'd0)));

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: a queue-backed FIFO model feeds bytes,
// expected payload/status events are queued at stimulus time and popped on DUT output.

module tb_uart_rx_frame_parser;

   localparam int unsigned MAX_LEN     = 32;
   localparam int unsigned TIMEOUT_CYC = 100;
   localparam logic [7:0]  HDR0        = 8'hAA;
   localparam logic [7:0]  HDR1        = 8'h55;

   logic       CLK = 1'b0;
   logic       RST;
   logic       En;
   logic       Empty_sig;
   logic [7:0] FIFO_RD_Dat;
   logic       RD_Req_sig;
   logic [7:0] Pay_Dat;
   logic       Pay_Vld;
   logic [7:0] Pay_Idx;
   logic [7:0] Frame_Len;
   logic       Frame_Done;
   logic [1:0] Frame_Err;

   uart_rx_frame_parser #(
      .MAX_LEN    (MAX_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .HDR0       (HDR0),
      .HDR1       (HDR1)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .En         (En),
      .Empty_sig  (Empty_sig),
      .FIFO_RD_Dat(FIFO_RD_Dat),
      .RD_Req_sig (RD_Req_sig),
      .Pay_Dat    (Pay_Dat),
      .Pay_Vld    (Pay_Vld),
      .Pay_Idx    (Pay_Idx),
      .Frame_Len  (Frame_Len),
      .Frame_Done (Frame_Done),
      .Frame_Err  (Frame_Err)
   );

   always #5 CLK = ~CLK;

   typedef enum logic [1:0] {EV_PAY, EV_DONE, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
      logic [7:0] idx;
      logic [1:0] code;
   } ev_t;

   ev_t        sb[$];
   logic [7:0] fifo_q[$];
   logic [7:0] pl_q[$];
   int         n_vec        = 0;
   int         n_err        = 0;
   int         cyc          = 0;
   int         rd_cnt       = 0;
   int         last_pay_cyc = 0;
   int         last_err_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void put(input logic [7:0] b);
      fifo_q.push_back(b);
   endfunction

   function automatic void exp_ev(input ev_kind_t k, input logic [7:0] d, input logic [7:0] i,
                                  input logic [1:0] c);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.idx  = i;
      e.code = c;
      sb.push_back(e);
   endfunction

   // Builds a frame from pl_q; a non-zero chk_delta corrupts the checksum byte.
   task automatic send_frame(input logic [7:0] chk_delta);
      logic [7:0] len;
      logic [7:0] sum;
      len = 8'(pl_q.size());
      sum = len;
      put(HDR0); put(HDR1); put(len);
      foreach (pl_q[i]) begin
         put(pl_q[i]);
         sum = sum + pl_q[i];
         exp_ev(EV_PAY, pl_q[i], 8'(i), 2'd0);
      end
      put(sum + chk_delta);
      if (chk_delta == 8'd0) exp_ev(EV_DONE, 8'd0, 8'd0, 2'd0);
      else                   exp_ev(EV_ERR, 8'd0, 8'd0, 2'd1);
      pl_q.delete();
   endtask

   task automatic take_event(input ev_kind_t k);
      ev_t e;
      if (sb.size() == 0) begin
         check({"unexpected_", k.name()}, 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check("ev_kind", 32'(k), 32'(e.kind));
      if (k == EV_PAY) begin
         check("pay_dat", 32'(Pay_Dat), 32'(e.data));
         check("pay_idx", 32'(Pay_Idx), 32'(e.idx));
      end
      if (k == EV_ERR) check("err_code", 32'(Frame_Err), 32'(e.code));
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((fifo_q.size() != 0 || sb.size() != 0) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_drain"}, 32'(fifo_q.size() + sb.size()), 32'd0);
      repeat (4) @(negedge CLK);
   endtask

   // FIFO read side: registered q, valid the cycle after the request.
   initial forever begin
      @(posedge CLK);
      if (RD_Req_sig) begin
         if (fifo_q.size() == 0) check("fifo_underflow", 32'(fifo_q.size()), 32'd1);
         else                    FIFO_RD_Dat <= fifo_q.pop_front();
      end
   end

   // Monitor samples away from the active edge.
   initial forever begin
      @(negedge CLK);
      cyc++;
      Empty_sig = (fifo_q.size() == 0);
      if (RD_Req_sig) rd_cnt++;
      if (Pay_Vld) begin
         last_pay_cyc = cyc;
         take_event(EV_PAY);
      end
      if (Frame_Done) take_event(EV_DONE);
      if (Frame_Err != 2'd0) begin
         last_err_cyc = cyc;
         take_event(EV_ERR);
      end
   end

   initial begin
      repeat (40000) @(posedge CLK);
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      int rd0;
      int n;
      RST         = 1'b1;
      En          = 1'b1;
      Empty_sig   = 1'b1;
      FIFO_RD_Dat = 8'h00;
      put(8'h12);
      repeat (3) @(negedge CLK);
      check("rst_rd_req",     32'(RD_Req_sig), 32'd0);
      check("rst_pay_vld",    32'(Pay_Vld),    32'd0);
      check("rst_pay_dat",    32'(Pay_Dat),    32'd0);
      check("rst_pay_idx",    32'(Pay_Idx),    32'd0);
      check("rst_frame_len",  32'(Frame_Len),  32'd0);
      check("rst_frame_done", 32'(Frame_Done), 32'd0);
      check("rst_frame_err",  32'(Frame_Err),  32'd0);
      RST = 1'b0;

      // Basic three-byte frame.
      put(8'hAA); put(8'h55); put(8'h03); put(8'h01); put(8'h02); put(8'h03); put(8'h09);
      exp_ev(EV_PAY, 8'h01, 8'd0, 2'd0);
      exp_ev(EV_PAY, 8'h02, 8'd1, 2'd0);
      exp_ev(EV_PAY, 8'h03, 8'd2, 2'd0);
      exp_ev(EV_DONE, 8'h00, 8'd0, 2'd0);
      wait_drain("t1", 200);
      check("t1_frame_len", 32'(Frame_Len), 32'd3);
      check("t1_pay_dat_hold", 32'(Pay_Dat), 32'h03);
      check("t1_pay_idx_hold", 32'(Pay_Idx), 32'd2);

      // Bad checksum, then a good frame.
      put(8'hAA); put(8'h55); put(8'h02); put(8'h10); put(8'h20); put(8'h31);
      exp_ev(EV_PAY, 8'h10, 8'd0, 2'd0);
      exp_ev(EV_PAY, 8'h20, 8'd1, 2'd0);
      exp_ev(EV_ERR, 8'h00, 8'd0, 2'd1);
      pl_q.push_back(8'h5A);
      send_frame(8'd0);
      wait_drain("t2", 300);

      // Length over the limit, zero-length frame, and exactly MAX_LEN.
      put(8'hAA); put(8'h55); put(8'h21);
      exp_ev(EV_ERR, 8'h00, 8'd0, 2'd2);
      wait_drain("t3a", 100);
      check("t3_len_over", 32'(Frame_Len), 32'h21);
      put(8'hAA); put(8'h55); put(8'h00); put(8'h00);
      exp_ev(EV_DONE, 8'h00, 8'd0, 2'd0);
      wait_drain("t3b", 100);
      check("t3_len_zero", 32'(Frame_Len), 32'd0);
      for (int i = 0; i < 32; i++) pl_q.push_back(8'(i * 7 + 3));
      send_frame(8'd0);
      wait_drain("t3c", 300);
      check("t3_len_max", 32'(Frame_Len), 32'd32);

      // Sync slips: leading junk, repeated AA, and an AA followed by a non-55.
      put(8'h12); put(8'hAA); put(8'hAA); put(8'h55); put(8'h01); put(8'h7F); put(8'h80);
      exp_ev(EV_PAY, 8'h7F, 8'd0, 2'd0);
      exp_ev(EV_DONE, 8'h00, 8'd0, 2'd0);
      put(8'hAA); put(8'h13); put(8'h55); put(8'hAA); put(8'h55); put(8'h01); put(8'h01); put(8'h02);
      exp_ev(EV_PAY, 8'h01, 8'd0, 2'd0);
      exp_ev(EV_DONE, 8'h00, 8'd0, 2'd0);
      wait_drain("t4", 300);

      // Random good frames.
      for (int f = 0; f < 4; f++) begin
         n = int'($urandom_range(8, 1));
         for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
         send_frame(8'd0);
      end
      wait_drain("trnd", 600);

      // Inter-byte gap just under the limit is tolerated.
      put(8'hAA); put(8'h55); put(8'h02); put(8'h01);
      exp_ev(EV_PAY, 8'h01, 8'd0, 2'd0);
      exp_ev(EV_PAY, 8'h02, 8'd1, 2'd0);
      exp_ev(EV_DONE, 8'h00, 8'd0, 2'd0);
      n = 0;
      while (sb.size() > 2 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("tgap_first_pay", 32'(sb.size()), 32'd2);
      repeat (90) @(negedge CLK);
      put(8'h02); put(8'h05);
      wait_drain("tgap", 100);

      // Timeout: stalled mid-payload, one error exactly TIMEOUT_CYC after the last byte.
      put(8'hAA); put(8'h55); put(8'h04); put(8'h01);
      exp_ev(EV_PAY, 8'h01, 8'd0, 2'd0);
      exp_ev(EV_ERR, 8'h00, 8'd0, 2'd3);
      wait_drain("t5", 400);
      check("t5_tmo_gap", 32'(last_err_cyc - last_pay_cyc), 32'(TIMEOUT_CYC));
      repeat (150) @(negedge CLK);
      pl_q.push_back(8'hC3);
      send_frame(8'd0);
      wait_drain("t5_resync", 100);

      // En low blocks reads even with data waiting.
      En = 1'b0;
      put(8'hAA); put(8'h55); put(8'h01); put(8'h44); put(8'h45);
      exp_ev(EV_PAY, 8'h44, 8'd0, 2'd0);
      exp_ev(EV_DONE, 8'h00, 8'd0, 2'd0);
      rd0 = rd_cnt;
      repeat (20) @(negedge CLK);
      check("t6_en_rd_req", 32'(rd_cnt - rd0), 32'd0);
      check("t6_en_fifo",   32'(fifo_q.size()), 32'd5);
      En = 1'b1;
      wait_drain("t6_en", 100);

      // Reset mid-payload, then re-sync.
      put(8'hAA); put(8'h55); put(8'h05); put(8'h01); put(8'h02);
      exp_ev(EV_PAY, 8'h01, 8'd0, 2'd0);
      exp_ev(EV_PAY, 8'h02, 8'd1, 2'd0);
      wait_drain("t6_pre", 100);
      RST = 1'b1;
      @(negedge CLK);
      check("t6_rst_frame_len", 32'(Frame_Len), 32'd0);
      check("t6_rst_pay_dat",   32'(Pay_Dat),   32'd0);
      check("t6_rst_pay_idx",   32'(Pay_Idx),   32'd0);
      check("t6_rst_frame_err", 32'(Frame_Err), 32'd0);
      RST = 1'b0;
      repeat (150) @(negedge CLK);
      pl_q.push_back(8'h33);
      send_frame(8'd0);
      wait_drain("t6_post", 100);

      check("sb_leftover", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
